// File: rtl/sha3_seq_pkg.sv
// rtl/sha3_seq_pkg.sv - shared state type and constants for the SHA-3 round sequencer
package sha3_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} seq_state_t;

  localparam int KECCAK_ROUNDS = 24;
  localparam int ROUND_IDX_W   = 5;

endpackage

// File: rtl/sha3_round_sequencer_if.sv
// rtl/sha3_round_sequencer_if.sv - handshake and datapath-control bundle of the round sequencer
interface sha3_round_sequencer_if;
  import sha3_seq_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   sample;
  logic                   load;
  logic [ROUND_IDX_W-1:0] round_idx;
  logic                   round_last;
  logic                   result_capture;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;
  logic [31:0]            perm_count;
  logic [31:0]            stall_cycles;

  modport slave (
    input  in_valid, out_ready,
    output in_ready, sample, load, round_idx, round_last, result_capture,
           out_valid, busy, perm_count, stall_cycles
  );

  modport master (
    output in_valid, out_ready,
    input  in_ready, sample, load, round_idx, round_last, result_capture,
           out_valid, busy, perm_count, stall_cycles
  );

endinterface

// File: rtl/sha3_round_timer.sv
// rtl/sha3_round_timer.sv - latency down-counter and round counter pacing the round strobes
module sha3_round_timer
  import sha3_seq_pkg::*;
#(
  parameter int ROUNDS        = KECCAK_ROUNDS,
  parameter int ROUND_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   start,
  output logic                   tick,
  output logic [ROUND_IDX_W-1:0] idx,
  output logic                   last,
  output logic                   done
);

  logic                   active;
  logic [3:0]             lat;
  logic [ROUND_IDX_W-1:0] nxt;
  logic                   expired;

  // Round 0 goes out with start itself, so nxt names the next round to issue.
  assign expired = active && (lat == 4'd0);
  assign tick    = expired && (nxt != ROUND_IDX_W'(ROUNDS));
  assign done    = expired && (nxt == ROUND_IDX_W'(ROUNDS));
  assign idx     = nxt;
  assign last    = (nxt == ROUND_IDX_W'(ROUNDS - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      active <= 1'b0;
      lat    <= 4'd0;
      nxt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      lat    <= 4'(ROUND_LATENCY - 1);
      nxt    <= ROUND_IDX_W'(1);
    end else if (tick) begin
      lat    <= 4'(ROUND_LATENCY - 1);
      nxt    <= nxt + ROUND_IDX_W'(1);
    end else if (done) begin
      active <= 1'b0;
    end else if (active) begin
      lat    <= lat - 4'd1;
    end
  end

endmodule

// File: rtl/sha3_round_sequencer.sv
// rtl/sha3_round_sequencer.sv - Keccak-f[1600] round control FSM; perf counters under SHA3_ROUND_SEQ_PERF_EN
module sha3_round_sequencer
  import sha3_seq_pkg::*;
#(
  parameter int ROUNDS        = KECCAK_ROUNDS,
  parameter int ROUND_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  sha3_round_sequencer_if.slave  bus
);

  seq_state_t             state;
  logic                   start;
  logic                   tick;
  logic                   last;
  logic                   done;
  logic [ROUND_IDX_W-1:0] idx;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign start        = bus.in_valid && bus.in_ready;

  sha3_round_timer #(
    .ROUNDS        (ROUNDS),
    .ROUND_LATENCY (ROUND_LATENCY)
  ) u_timer (
    .clk   (clk),
    .clear (rst),
    .start (start),
    .tick  (tick),
    .idx   (idx),
    .last  (last),
    .done  (done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bus.sample         <= 1'b0;
      bus.load           <= 1'b0;
      bus.round_idx      <= '0;
      bus.round_last     <= 1'b0;
      bus.result_capture <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.busy           <= 1'b0;
    end else begin
      bus.sample         <= 1'b0;
      bus.load           <= 1'b0;
      bus.round_last     <= 1'b0;
      bus.result_capture <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state          <= RUN;
            bus.busy       <= 1'b1;
            bus.sample     <= 1'b1;
            bus.load       <= 1'b1;
            bus.round_idx  <= '0;
            bus.round_last <= (ROUNDS == 1);
          end
        end
        RUN: begin
          if (tick) begin
            bus.sample     <= 1'b1;
            bus.round_idx  <= idx;
            bus.round_last <= last;
          end
          if (done) begin
            bus.result_capture <= 1'b1;
            state              <= HOLD;
          end
        end
        HOLD: begin
          // out_valid follows the capture cycle so the output register is already loaded
          if (bus.result_capture) begin
            bus.out_valid <= 1'b1;
          end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SHA3_ROUND_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.perm_count   <= '0;
      bus.stall_cycles <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.perm_count <= bus.perm_count + 32'd1;
      end
      if (bus.out_valid && !bus.out_ready) begin
        bus.stall_cycles <= bus.stall_cycles + 32'd1;
      end
    end
  end
`else
  assign bus.perm_count   = '0;
  assign bus.stall_cycles = '0;
`endif

endmodule

// File: tb/tb_sha3_round_sequencer.sv
// tb/tb_sha3_round_sequencer.sv - directed self-checking bench for sha3_round_sequencer
module tb_sha3_round_sequencer;

`ifdef SHA3_ROUND_SEQ_PERF_EN
  localparam int EXP_PERMS  = 3;
  localparam int EXP_STALLS = 4;
`else
  localparam int EXP_PERMS  = 0;
  localparam int EXP_STALLS = 0;
`endif

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sha3_round_sequencer_if bus_a ();
  sha3_round_sequencer_if bus_b ();

  sha3_round_sequencer #(.ROUNDS(24), .ROUND_LATENCY(2)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  sha3_round_sequencer #(.ROUNDS(24), .ROUND_LATENCY(1)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int   sa_cyc[$], sa_idx[$], sa_load[$], sa_last[$], ca_q[$], ova_q[$], acca_q[$];
  int   sb_cyc[$], ovb_q[$], accb_q[$];
  logic ova_d = 1'b0;
  logic ovb_d = 1'b0;

  always @(negedge clk) begin
    if (bus_a.sample === 1'b1) begin
      sa_cyc.push_back(cyc);
      sa_idx.push_back(int'(bus_a.round_idx));
      sa_load.push_back(int'(bus_a.load));
      sa_last.push_back(int'(bus_a.round_last));
    end
    if (bus_a.result_capture === 1'b1) ca_q.push_back(cyc);
    if (bus_a.out_valid === 1'b1 && !ova_d) ova_q.push_back(cyc);
    ova_d = (bus_a.out_valid === 1'b1);
    if (bus_a.in_valid && bus_a.in_ready === 1'b1) acca_q.push_back(cyc);
    if (bus_b.sample === 1'b1) sb_cyc.push_back(cyc);
    if (bus_b.out_valid === 1'b1 && !ovb_d) ovb_q.push_back(cyc);
    ovb_d = (bus_b.out_valid === 1'b1);
    if (bus_b.in_valid && bus_b.in_ready === 1'b1) accb_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int n);
    goto(n);
    @(negedge clk);
  endtask

  task automatic clear_a();
    sa_cyc.delete(); sa_idx.delete(); sa_load.delete(); sa_last.delete();
    ca_q.delete(); ova_q.delete(); acca_q.delete();
  endtask

  // Full 24-round sequence at latency 2 for a permutation accepted in cycle t.
  task automatic check_run(input string tag, input int t);
    check({tag, "_nsmp"}, sa_cyc.size(), 24);
    foreach (sa_cyc[k]) begin
      check($sformatf("%s_cyc%0d", tag, k), sa_cyc[k], t + 1 + 2 * k);
      check($sformatf("%s_idx%0d", tag, k), sa_idx[k], k);
      check($sformatf("%s_load%0d", tag, k), sa_load[k], (k == 0));
      check($sformatf("%s_last%0d", tag, k), sa_last[k], (k == 23));
    end
    check({tag, "_ncap"}, ca_q.size(), 1);
    if (ca_q.size() > 0) check({tag, "_cap"}, ca_q[0], t + 49);
    check({tag, "_nov"}, ova_q.size(), 1);
    if (ova_q.size() > 0) check({tag, "_ovrise"}, ova_q[0], t + 50);
  endtask

  task automatic perm_b(input int t, input int stalls);
    goto(t);              bus_b.in_valid  = 1'b1;
    goto(t + 1);          bus_b.in_valid  = 1'b0;
    goto(t + 26 + stalls); bus_b.out_ready = 1'b1;
    goto(t + 27 + stalls); bus_b.out_ready = 1'b0;
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;

    at_neg(1);
    check("rst_sample", bus_a.sample, 0);
    check("rst_outvalid", bus_a.out_valid, 0);
    check("rst_busy", bus_a.busy, 0);
    check("rst_idx", bus_a.round_idx, 0);
    check("rst_inready", bus_a.in_ready, 0);
    goto(2); rst_a = 1'b0;
    at_neg(2);
    check("idle_inready", bus_a.in_ready, 1);

    // Scenario 1: nominal permutation accepted in cycle 5
    goto(5); bus_a.in_valid = 1'b1;
    goto(6); bus_a.in_valid = 1'b0;
    at_neg(30);
    check("s1_busy", bus_a.busy, 1);
    check("s1_inready_run", bus_a.in_ready, 0);
    at_neg(56);
    check("s1_ov_drop", bus_a.out_valid, 0);
    check("s1_inready_back", bus_a.in_ready, 1);
    goto(60);
    check_run("s1", 5);

    // Scenario 2: downstream stalls 10 cycles, input pending during HOLD
    clear_a();
    bus_a.out_ready = 1'b0;
    goto(70); bus_a.in_valid = 1'b1;
    goto(71); bus_a.in_valid = 1'b0;
    for (int c = 120; c < 130; c++) begin
      if (c == 125) begin
        goto(c);
        bus_a.in_valid = 1'b1;
      end
      at_neg(c);
      check($sformatf("s2_ov_%0d", c), bus_a.out_valid, 1);
      check($sformatf("s2_inrdy_%0d", c), bus_a.in_ready, 0);
      check($sformatf("s2_smp_%0d", c), bus_a.sample, 0);
    end
    goto(130); bus_a.out_ready = 1'b1;
    at_neg(131);
    check("s2_ov_drop", bus_a.out_valid, 0);
    check("s2_inready", bus_a.in_ready, 1);
    goto(132); bus_a.in_valid = 1'b0;
    at_neg(132);
    check("s2_restart_load", bus_a.load, 1);
    goto(140);
    check("s2_nacc", acca_q.size(), 2);
    if (acca_q.size() > 1) begin
      check("s2_acc0", acca_q[0], 70);
      check("s2_acc1", acca_q[1], 131);
    end
    if (ca_q.size() > 0) check("s2_cap", ca_q[0], 119);
    if (ova_q.size() > 0) check("s2_ovrise", ova_q[0], 120);

    // Scenario 3: in_valid pulse at round 5 must not disturb the run
    goto(190); clear_a();
    goto(200); bus_a.in_valid = 1'b1;
    goto(201); bus_a.in_valid = 1'b0;
    goto(211); bus_a.in_valid = 1'b1;
    goto(212); bus_a.in_valid = 1'b0;
    goto(255);
    check_run("s3", 200);
    check("s3_nacc", acca_q.size(), 1);

    // Scenario 4: reset during round 7 aborts without capture
    goto(258); clear_a();
    goto(260); bus_a.in_valid = 1'b1;
    goto(261); bus_a.in_valid = 1'b0;
    goto(275); rst_a = 1'b1;
    at_neg(275);
    check("s4_r7_idx", bus_a.round_idx, 7);
    check("s4_rst_inready", bus_a.in_ready, 0);
    goto(276); rst_a = 1'b0;
    at_neg(276);
    check("s4_sample", bus_a.sample, 0);
    check("s4_load", bus_a.load, 0);
    check("s4_last", bus_a.round_last, 0);
    check("s4_capture", bus_a.result_capture, 0);
    check("s4_outvalid", bus_a.out_valid, 0);
    check("s4_busy", bus_a.busy, 0);
    check("s4_idx", bus_a.round_idx, 0);
    check("s4_inready", bus_a.in_ready, 1);
    goto(325);
    check("s4_ncap", ca_q.size(), 0);
    check("s4_nsmp", sa_cyc.size(), 8);
    clear_a();
    goto(330); bus_a.in_valid = 1'b1;
    goto(331); bus_a.in_valid = 1'b0;
    goto(385);
    check_run("s4r", 330);

    // Scenario 6: perf counters on the latency-1 instance, 3 perms with 1+1+2 stalls
    goto(400); rst_b = 1'b0;
    perm_b(405, 1);
    perm_b(440, 1);
    perm_b(480, 2);
    at_neg(515);
    check("s6_perm_count", bus_b.perm_count, EXP_PERMS);
    check("s6_stall_cycles", bus_b.stall_cycles, EXP_STALLS);
    check("s6_nov", ovb_q.size(), 3);
    if (ovb_q.size() > 2) check("s6_ovrise2", ovb_q[2], 506);
    goto(520); rst_b = 1'b1;
    goto(521); rst_b = 1'b0;
    at_neg(521);
    check("s6_rst_perm", bus_b.perm_count, 0);
    check("s6_rst_stall", bus_b.stall_cycles, 0);
    check("s6_rst_busy", bus_b.busy, 0);

    // Scenario 5: latency 1, in_valid and out_ready tied high
    goto(523);
    sb_cyc.delete(); accb_q.delete();
    goto(525); bus_b.in_valid = 1'b1; bus_b.out_ready = 1'b1;
    goto(620); bus_b.in_valid = 1'b0;
    goto(640);
    check("s5_nacc", accb_q.size(), 4);
    if (accb_q.size() > 3) begin
      check("s5_acc0", accb_q[0], 525);
      for (int i = 1; i < 4; i++) check($sformatf("s5_period%0d", i), accb_q[i] - accb_q[i-1], 27);
    end
    if (sb_cyc.size() > 24) begin
      for (int k = 0; k < 24; k++) check($sformatf("s5_smp%0d", k), sb_cyc[k], 526 + k);
      check("s5_next_perm_smp", sb_cyc[24], 553);
    end else begin
      check("s5_nsmp", sb_cyc.size(), 25);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha3_round_sequencer.md
Name: sha3_round_sequencer

Overview:
Control FSM for the iterative Keccak-f[1600] round datapath (theta-elts → theta/rho/pi/chi/iota → feedback). Accepts one 1600-bit state per permutation from an upstream valid/ready source and issues a fixed number of round strobes. Each strobe is spaced by the datapath's pipeline latency and carries the round index for the iota constant. When the last round completes, it captures the result and presents it downstream under valid/ready. Contains no state bits itself; it only drives datapath enables/selects.

Parameters:
ROUNDS, 24, number of rounds per permutation; legal 1..31.
ROUND_LATENCY, 2, cycles from a round's sample strobe to its result at the feedback mux; legal 1..15.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  upstream has a state ready on the datapath input bus.
in_ready  out  1  sequencer accepts a new permutation this cycle.
sample  out  1  one-cycle strobe: datapath samples its round input (theta-elts sample).
load  out  1  high with sample only for round 0: input mux selects fresh state, not feedback.
round_idx  out  5  index of the round being issued; valid while sample=1, holds last value otherwise.
round_last  out  1  high with sample when round_idx==ROUNDS-1.
result_capture  out  1  one-cycle enable: output register captures the final round result.
out_valid  out  1  output register holds a completed permutation.
out_ready  in  1  downstream accepts the result.
busy  out  1  high in any state other than IDLE.
perm_count  out  32  completed permutations (feature-dependent, see below).
stall_cycles  out  32  cycles with out_valid && !out_ready (feature-dependent).

Behaviour:
- States: IDLE, RUN, HOLD; all outputs registered except in_ready = (state==IDLE) && !rst.
- Reset (synchronous): state=IDLE; sample, load, round_last, result_capture, out_valid, busy=0; round_idx=0; internal latency counter=0. Reset mid-RUN or mid-HOLD aborts the permutation with no capture; the result is lost. Reset has priority over every other event in the same cycle.
- IDLE: if in_valid && in_ready at cycle T → RUN. At T+1: sample=1, load=1, round_idx=0.
- RUN: round k is issued at cycle T+1+k*ROUND_LATENCY with sample=1, round_idx=k, and load=(k==0). sample is 0 on all other cycles.
- In RUN, in_valid is ignored and in_ready=0.
- Completion: at cycle C=T+1+ROUNDS*ROUND_LATENCY, result_capture=1 and state→HOLD. out_valid=1 from C+1.
- HOLD: out_valid stays high until out_valid && out_ready; then state→IDLE, and out_valid=0 on the next cycle. No new input is accepted in HOLD.
- Throughput with out_ready tied 1: one permutation per ROUNDS*ROUND_LATENCY+3 cycles.
- Latency counter: wraps 0..ROUND_LATENCY-1. With ROUND_LATENCY=1, sample is high on ROUNDS consecutive cycles.
- Round counter never exceeds ROUNDS-1 and resets to 0 on each accept.
- Simultaneous in_valid with out_ready in HOLD: the output handshake completes; the input is not accepted until IDLE.

Optional Feature:
SHA3_ROUND_SEQ_PERF_EN:
- Defined: perm_count increments on each output handshake. stall_cycles increments each cycle out_valid && !out_ready. Both are 32-bit, wrap at 2^32, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesized; the port list is unchanged.

Decomposition:
- Package sha3_seq_pkg: state enum (IDLE, RUN, HOLD), KECCAK_ROUNDS=24, ROUND_IDX_W=5.
- One sub-module, sha3_round_timer: latency down-counter plus round counter. Inputs start and clear; outputs tick, idx, last, done.
- FSM and handshakes stay in the top module.

Test Plan:
1. Defaults, in_valid at cycle 5 → sample at 6, 8, …, 52 with idx 0..23; load only at 6; round_last at 52; result_capture at 54; out_valid rises at 55.
2. out_ready low 10 cycles after out_valid → out_valid held, in_ready=0, no sample pulses; after the handshake, in_ready=1 on the next cycle.
3. in_valid pulsed during RUN at round 5 → ignored; round sequence and capture timing identical to scenario 1.
4. rst high for 1 cycle during round 7 → next cycle all outputs 0 and busy=0, no result_capture ever. A new input restarts at idx 0.
5. ROUNDS=24, ROUND_LATENCY=1, in_valid and out_ready tied 1 → 24 consecutive sample cycles, accepts exactly every 27 cycles.
6. PERF_EN defined, 3 permutations with 4 stall cycles total → perm_count=3, stall_cycles=4. Undefined → both read 0.
